hub_norm_shift: RTL and testbench
=================================

Name: hub_norm_shift

Overview:
- Normalization back end of the HUB floating-point adder datapath; consumes the leading-zero count produced by the LZD stage.
- Takes the raw effective-subtraction mantissa, its exponent and the leading-zero count.
- Left-shifts the mantissa so the MSB is set and subtracts the count from the exponent.
- Handles zero and underflow; 2-stage pipeline with valid/ready handshake on both sides.

Parameters:
- M, 23, stored mantissa width; datapath mantissa is M+2 bits.
- E, 8, exponent width.
- SHIFT_WIDTH, $clog2(M+1), width of the leading-zero count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_mant  in  M+2  unnormalized mantissa (A-B).
- in_exp  in  E  exponent before normalization.
- in_lzc  in  SHIFT_WIDTH  leading-zero count of in_mant.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_mant  out  M+2  normalized mantissa, bit M+1 set unless zero/flush.
- out_exp  out  E  adjusted exponent.
- out_zero  out  1  exact-zero result.
- out_uf  out  1  underflow flush occurred.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_mant=0, out_exp=0, out_zero=0, out_uf=0. in_ready=1 after reset.
- Pipeline: stage 1 registers the inputs and applies the coarse shift (in_lzc[SHIFT_WIDTH-1:2]*4). Stage 2 applies the fine shift (in_lzc[1:0]), computes the exponent and sets the flags.
- Latency: exactly 2 cycles from accept to out_valid with no backpressure. Throughput: 1 beat/cycle.
- Handshake:
  - Stage k advances when its successor is empty or is being drained the same cycle.
  - in_ready = !s1_valid || s1_adv.
  - out_valid, out_mant, out_exp, out_zero and out_uf hold stable while out_valid && !out_ready.
  - No combinational path from out_ready to in_ready beyond one AND/OR level. No beat is lost or duplicated; order is preserved.
- Zero: in_mant==0 (the count is meaningless here, since the LZD returns 0 for zero input) -> out_mant=0, out_exp=0, out_zero=1, out_uf=0.
- Clamp: in_lzc > M+1 is clamped to M+1 in stage 1.
- Normal case (in_mant!=0, in_exp > lzc): out_mant = in_mant << lzc, zero-filled; out_exp = in_exp - lzc; flags 0.
- Underflow (in_mant!=0, in_exp <= lzc): flush; out_mant=0, out_exp=0, out_zero=1, out_uf=1. Exponent 0 is reserved. HUB has no subnormals.
- Exponent arithmetic is done in E+1 bits; the borrow defines underflow.
- Reset mid-operation: all in-flight beats are discarded; nothing is emitted after release until new input arrives.

Optional Feature:
- Macro: HUB_NORM_UF_CNT_EN.
- Defined: adds output port uf_count (16 bits), a saturating count of beats delivered (out_valid && out_ready) with out_uf=1. It resets to 0 and holds at 16'hFFFF.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package hub_fp_pkg holds:
  - the default M and E;
  - the shift-width localparam function;
  - the typedef norm_beat_t struct {mant, exp, lzc, zero, uf}.
- Sub-module hub_pipe_slice: one valid/ready register slice carrying norm_beat_t, instantiated twice. The shift and exponent logic sits between the slices.

Test Plan (M=23, E=8):
- Normal: in_mant=25'h000400, in_exp=100, in_lzc=14 -> 2 cycles later out_mant=25'h1000000, out_exp=86, zero=0, uf=0.
- Zero: in_mant=0, in_exp=57, in_lzc=0 -> out_mant=0, out_exp=0, out_zero=1, out_uf=0.
- Underflow boundary:
  - in_mant=25'h000400, in_exp=14, in_lzc=14 -> flush, out_zero=1, out_uf=1.
  - Same with in_exp=15 -> out_exp=1, out_uf=0.
- Backpressure: out_ready=0 for 4 cycles while 4 beats are offered back-to-back -> exactly 2 accepted, then in_ready=0. Outputs stay stable. After release all 4 emerge in order, 1/cycle.
- Reset mid-flight: both stages valid, assert rst_n=0 mid-cycle -> out_valid=0 immediately. After release, no stale beats appear and in_ready=1.
- With HUB_NORM_UF_CNT_EN defined: 3 underflow beats delivered -> uf_count=3. Preloaded to 16'hFFFF, one more -> stays 16'hFFFF.

Source files
------------

// File: rtl/hub_fp_pkg.sv
// Shared widths and beat layout for the HUB floating-point normalization path.
// The defaults give single precision: 23 stored mantissa bits and an 8-bit exponent.
package hub_fp_pkg;

    localparam int HUB_M = 23;
    localparam int HUB_E = 8;

    // Width of a leading-zero count for an (m+2)-bit datapath mantissa.
    function automatic int shift_width(input int m);
        return $clog2(m + 1);
    endfunction

    localparam int HUB_SW = shift_width(HUB_M);

    typedef struct packed {
        logic [HUB_M+1:0]  mant;
        logic [HUB_E-1:0]  exp;
        logic [HUB_SW-1:0] lzc;
        logic              zero;
        logic              uf;
    } norm_beat_t;

endpackage

// File: rtl/hub_pipe_slice.sv
// Purpose: single valid/ready register slice carrying one normalization beat.
// Latency: 1 cycle, full throughput.
// Backpressure: accepts when empty or drained the same cycle; holds data while stalled.
module hub_pipe_slice
    import hub_fp_pkg::*;
#(
    parameter type T = norm_beat_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic up_vld,
    output logic up_rdy,
    input  T     up_dat,
    output logic dn_vld,
    input  logic dn_rdy,
    output T     dn_dat
);

    assign up_rdy = !dn_vld || dn_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_vld <= 1'b0;
            dn_dat <= '0;
        end else if (up_rdy) begin
            dn_vld <= up_vld;
            if (up_vld) begin
                dn_dat <= up_dat;
            end
        end
    end

endmodule

// File: rtl/hub_norm_shift.sv
// Purpose: HUB adder normalization -- left-shift by the LZD count, adjust exponent, flag zero/underflow.
// Latency: 2 cycles accept-to-out_valid, 1 beat/cycle; optional HUB_NORM_UF_CNT_EN adds uf_count.
// Backpressure: two valid/ready slices; outputs hold while out_valid && !out_ready.
module hub_norm_shift
    import hub_fp_pkg::*;
#(
    parameter int M           = HUB_M,
    parameter int E           = HUB_E,
    parameter int SHIFT_WIDTH = shift_width(M)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [M+1:0]           in_mant,
    input  logic [E-1:0]           in_exp,
    input  logic [SHIFT_WIDTH-1:0] in_lzc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [M+1:0]           out_mant,
    output logic [E-1:0]           out_exp,
    output logic                   out_zero,
    output logic                   out_uf
`ifdef HUB_NORM_UF_CNT_EN
    ,
    output logic [15:0]            uf_count
`endif
);

    typedef struct packed {
        logic [M+1:0]           mant;
        logic [E-1:0]           exp;
        logic [SHIFT_WIDTH-1:0] lzc;
        logic                   zero;
        logic                   uf;
    } beat_t;

    localparam logic [SHIFT_WIDTH-1:0] LZC_MAX = SHIFT_WIDTH'(M + 1);
    localparam int                     EXW     = E + 1;

    beat_t                  s0_dat;
    beat_t                  s1_dat;
    beat_t                  s1n_dat;
    beat_t                  s2_dat;
    logic                   s1_valid;
    logic                   s1_ready;
    logic [SHIFT_WIDTH-1:0] lzc_clamped;
    logic [SHIFT_WIDTH-1:0] coarse_sh;
    logic [E:0]             exp_diff;
    logic                   flush_uf;

    // Stage 1 input: clamp the count and apply the multiple-of-4 part of the shift.
    always_comb begin
        lzc_clamped = (in_lzc > LZC_MAX) ? LZC_MAX : in_lzc;
        coarse_sh   = {lzc_clamped[SHIFT_WIDTH-1:2], 2'b00};
        s0_dat      = '0;
        s0_dat.mant = in_mant << coarse_sh;
        s0_dat.exp  = in_exp;
        s0_dat.lzc  = lzc_clamped;
        s0_dat.zero = (in_mant == '0);
    end

    hub_pipe_slice #(.T(beat_t)) u_s1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .up_vld (in_valid),
        .up_rdy (in_ready),
        .up_dat (s0_dat),
        .dn_vld (s1_valid),
        .dn_rdy (s1_ready),
        .dn_dat (s1_dat)
    );

    // The borrow out of the widened subtraction, or a zero result, means the
    // exponent would land on the reserved value 0 or below: flush to zero.
    always_comb begin
        exp_diff      = {1'b0, s1_dat.exp} - EXW'(s1_dat.lzc);
        flush_uf      = !s1_dat.zero && (exp_diff[E] || (exp_diff[E-1:0] == '0));
        s1n_dat       = '0;
        s1n_dat.zero  = s1_dat.zero || flush_uf;
        s1n_dat.uf    = flush_uf;
        if (!(s1_dat.zero || flush_uf)) begin
            s1n_dat.mant = s1_dat.mant << s1_dat.lzc[1:0];
            s1n_dat.exp  = exp_diff[E-1:0];
        end
    end

    hub_pipe_slice #(.T(beat_t)) u_s2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .up_vld (s1_valid),
        .up_rdy (s1_ready),
        .up_dat (s1n_dat),
        .dn_vld (out_valid),
        .dn_rdy (out_ready),
        .dn_dat (s2_dat)
    );

    assign out_mant = s2_dat.mant;
    assign out_exp  = s2_dat.exp;
    assign out_zero = s2_dat.zero;
    assign out_uf   = s2_dat.uf;

    logic unused_bits;
    assign unused_bits = ^{s1_dat.uf, s2_dat.lzc};

`ifdef HUB_NORM_UF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf_count <= '0;
        end else if (out_valid && out_ready && out_uf && (uf_count != 16'hFFFF)) begin
            uf_count <= uf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hub_norm_shift.sv
// Bench for hub_norm_shift: driver pushes expected beats into a scoreboard on acceptance,
// an independent monitor pops and compares on every delivered output beat.
module tb_hub_norm_shift;

    localparam int M  = 23;
    localparam int E  = 8;
    localparam int SW = 5;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [M+1:0]  in_mant   = '0;
    logic [E-1:0]  in_exp    = '0;
    logic [SW-1:0] in_lzc    = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [M+1:0]  out_mant;
    logic [E-1:0]  out_exp;
    logic          out_zero;
    logic          out_uf;
`ifdef HUB_NORM_UF_CNT_EN
    logic [15:0]   uf_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bp_mode  = 0;
    int uf_model = 0;

    typedef struct {
        logic [M+1:0] mant;
        logic [E-1:0] exp;
        logic         zero;
        logic         uf;
        int           acc_cyc;
        bit           lat_exact;
    } exp_t;

    exp_t sb[$];
    int   deliv_cyc[$];
    exp_t mx;

    hub_norm_shift #(.M(M), .E(E), .SHIFT_WIDTH(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .in_lzc    (in_lzc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_uf    (out_uf)
`ifdef HUB_NORM_UF_CNT_EN
        ,
        .uf_count  (uf_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: normalize by the (clamped) count, flush whenever the exponent would reach 0.
    function automatic exp_t model(input logic [M+1:0] m, input logic [E-1:0] e, input logic [SW-1:0] l);
        exp_t r;
        int   lz;
        r.mant = '0; r.exp = '0; r.zero = 1'b0; r.uf = 1'b0; r.acc_cyc = 0; r.lat_exact = 1'b0;
        lz = (int'(l) > M + 1) ? M + 1 : int'(l);
        if (m == '0) begin
            r.zero = 1'b1;
        end else if (int'(e) <= lz) begin
            r.zero = 1'b1;
            r.uf   = 1'b1;
        end else begin
            r.mant = m << lz;
            r.exp  = E'(int'(e) - lz);
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [M+1:0] m, input logic [E-1:0] e, input bit z, input bit u, input bit lat);
        exp_t r;
        r.mant = m; r.exp = e; r.zero = z; r.uf = u; r.acc_cyc = 0; r.lat_exact = lat;
        return r;
    endfunction

    // Caller is positioned just after a rising edge; returns just after a rising edge.
    task automatic send(input logic [M+1:0] m, input logic [E-1:0] e, input logic [SW-1:0] l, input exp_t x);
        int w    = 0;
        bit done = 1'b0;
        in_valid = 1'b1; in_mant = m; in_exp = e; in_lzc = l;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                x.acc_cyc = cyc;
                sb.push_back(x);
                done = 1'b1;
            end
            @(posedge clk); #1;
            w++;
            if (!done && w > 1000) begin
                chk(1'b0, "accept_timeout", 64'(w), 64'd1000);
                done = 1'b1;
            end
        end
    endtask

    task automatic send_m(input logic [M+1:0] m, input logic [E-1:0] e, input logic [SW-1:0] l, input bit lat);
        exp_t x;
        x = model(m, e, l);
        x.lat_exact = lat;
        send(m, e, l, x);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int w = 0;
        in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid) && w < 3000) begin
            @(posedge clk); #1;
            w++;
        end
        chk(sb.size() == 0 && !out_valid, "drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: stall stability, then scoreboard comparison of each delivered beat.
    logic [M+1:0] h_mant;
    logic [E-1:0] h_exp;
    logic         h_zero;
    logic         h_uf;
    bit           h_vld = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            h_vld = 1'b0;
        end else begin
            if (h_vld)
                chk(out_valid && out_mant == h_mant && out_exp == h_exp && out_zero == h_zero && out_uf == h_uf,
                    "stall_stable", 64'({out_valid, out_mant, out_exp, out_zero, out_uf}),
                    64'({1'b1, h_mant, h_exp, h_zero, h_uf}));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_beat", 64'({out_mant, out_exp}), 64'd0);
                end else begin
                    mx = sb.pop_front();
                    chk({out_mant, out_exp, out_zero, out_uf} == {mx.mant, mx.exp, mx.zero, mx.uf}, "beat_data",
                        64'({out_mant, out_exp, out_zero, out_uf}), 64'({mx.mant, mx.exp, mx.zero, mx.uf}));
                    if (mx.lat_exact)
                        chk(cyc - mx.acc_cyc == 2, "latency", 64'(cyc - mx.acc_cyc), 64'd2);
                    else
                        chk(cyc - mx.acc_cyc >= 2, "latency_min", 64'(cyc - mx.acc_cyc), 64'd2);
                end
                if (out_uf && uf_model < 65535) uf_model++;
                deliv_cyc.push_back(cyc);
                if (deliv_cyc.size() > 8) void'(deliv_cyc.pop_front());
            end
            h_vld  = out_valid && !out_ready;
            h_mant = out_mant; h_exp = out_exp; h_zero = out_zero; h_uf = out_uf;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        chk(out_mant == '0, "rst_out_mant", 64'(out_mant), 64'd0);
        chk(out_exp == '0, "rst_out_exp", 64'(out_exp), 64'd0);
        chk(out_zero == 1'b0, "rst_out_zero", 64'(out_zero), 64'd0);
        chk(out_uf == 1'b0, "rst_out_uf", 64'(out_uf), 64'd0);
        chk(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk(in_ready == 1'b1, "ready_after_reset", 64'(in_ready), 64'd1);

        // Directed values with independently worked-out results.
        send(25'h0000400, 8'd100, 5'd14, mk(25'h1000000, 8'd86,  1'b0, 1'b0, 1'b1));
        send(25'h0000000, 8'd57,  5'd0,  mk(25'h0000000, 8'd0,   1'b1, 1'b0, 1'b1));
        send(25'h0000400, 8'd14,  5'd14, mk(25'h0000000, 8'd0,   1'b1, 1'b1, 1'b1));
        send(25'h0000400, 8'd15,  5'd14, mk(25'h1000000, 8'd1,   1'b0, 1'b0, 1'b1));
        send(25'h0000001, 8'd200, 5'd31, mk(25'h1000000, 8'd176, 1'b0, 1'b0, 1'b1));
        send(25'h1800000, 8'd5,   5'd0,  mk(25'h1800000, 8'd5,   1'b0, 1'b0, 1'b1));
        send(25'h0000003, 8'd255, 5'd23, mk(25'h1800000, 8'd232, 1'b0, 1'b0, 1'b1));
        send(25'h0000010, 8'd20,  5'd20, mk(25'h0000000, 8'd0,   1'b1, 1'b1, 1'b1));
        send(25'h0000001, 8'd24,  5'd24, mk(25'h0000000, 8'd0,   1'b1, 1'b1, 1'b1));
        wait_drain();

        // Backpressure: four beats offered against a stalled output.
        bp_mode = 2;
        idle(3);
        begin
            int acc;
            int n;
            exp_t x;
            acc = 0;
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                in_mant  = 25'h0000100 << acc;
                in_exp   = 8'(60 + acc);
                in_lzc   = 5'(16 - acc);
                @(negedge clk);
                if (in_ready) begin
                    x = model(in_mant, in_exp, in_lzc);
                    x.acc_cyc = cyc;
                    sb.push_back(x);
                    acc++;
                end
                @(posedge clk); #1;
            end
            chk(acc == 2, "bp_accepted", 64'(acc), 64'd2);
            chk(in_ready == 1'b0, "bp_in_ready", 64'(in_ready), 64'd0);
            bp_mode = 0;
            for (int i = acc; i < 4; i++)
                send_m(25'h0000100 << i, 8'(60 + i), 5'(16 - i), 1'b0);
            wait_drain();
            n = deliv_cyc.size();
            chk(n >= 4 && deliv_cyc[n-1] - deliv_cyc[n-4] == 3, "bp_release_rate",
                64'(n >= 4 ? deliv_cyc[n-1] - deliv_cyc[n-4] : -1), 64'd3);
        end

        // Randomized traffic with random output stalls.
        bp_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            logic [M+1:0]  m;
            logic [E-1:0]  e;
            logic [SW-1:0] l;
            int            k;
            k = $urandom_range(0, M + 1);
            m = 25'(1) << (M + 1 - k);
            m = m | (25'($urandom) & (m - 25'd1));
            l = SW'(k);
            if ($urandom_range(0, 9) == 0) l = SW'($urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) m = '0;
            e = ($urandom_range(0, 2) == 0) ? E'($urandom_range(0, 30)) : E'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_m(m, e, l, 1'b0);
        end
        bp_mode = 0;
        wait_drain();

        // Reset with both stages occupied.
        bp_mode = 2;
        idle(2);
        send_m(25'h0000800, 8'd90, 5'd13, 1'b0);
        send_m(25'h0000004, 8'd40, 5'd22, 1'b0);
        in_valid = 1'b0;
        chk(out_valid == 1'b1 && in_ready == 1'b0, "rst_pre_full", 64'({out_valid, in_ready}), 64'h2);
        #2 rst_n = 1'b0;
        sb.delete();
        uf_model = 0;
        #1;
        chk(out_valid == 1'b0, "rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk(in_ready == 1'b1, "rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk(out_mant == '0 && out_exp == '0, "rst_mid_data", 64'({out_mant, out_exp}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        bp_mode = 0;
        repeat (6) begin
            @(negedge clk);
            chk(out_valid == 1'b0, "no_stale_beat", 64'(out_valid), 64'd0);
        end
        chk(in_ready == 1'b1, "ready_after_mid_reset", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        send_m(25'h0040000, 8'd30, 5'd6, 1'b1);
        wait_drain();

`ifdef HUB_NORM_UF_CNT_EN
        chk(uf_count == 16'd0, "ufc_after_reset", 64'(uf_count), 64'd0);
        repeat (3) send_m(25'h0000400, 8'd5, 5'd14, 1'b0);
        send_m(25'h0000400, 8'd50, 5'd14, 1'b0);
        wait_drain();
        chk(uf_count == 16'd3, "ufc_three", 64'(uf_count), 64'd3);
        repeat (65532) send_m(25'h0000001, 8'd3, 5'd24, 1'b0);
        wait_drain();
        chk(uf_count == 16'hFFFF, "ufc_full", 64'(uf_count), 64'hFFFF);
        chk(uf_count == 16'(uf_model), "ufc_model", 64'(uf_count), 64'(uf_model));
        send_m(25'h0000001, 8'd3, 5'd24, 1'b0);
        wait_drain();
        chk(uf_count == 16'hFFFF, "ufc_saturate", 64'(uf_count), 64'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
